// File: rtl/skid_buffer_pipe.sv
// Single valid/ready pipeline stage with a main register and one skid entry.
// Latency: one cycle; a word accepted on a clock edge is on m_data/m_valid right after that edge.
// Backpressure: s_ready is a pure decode of registered state and drops only when both entries are held.
//
// Ports:
//   clk, rst_n                clock and asynchronous active-low reset
//   s_valid/s_ready/s_data    upstream handshake and data
//   m_valid/m_ready/m_data    downstream handshake and data (m_data is the main entry)
//   count                     number of held entries: 0, 1 or 2
module skid_buffer_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       count
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic main_from_in;
    logic main_from_skid;
    logic skid_load;

    assign in_fire  = s_valid & s_ready;
    assign out_fire = m_valid & m_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and data-path enables.
    always_comb begin
        state_nxt      = state;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    main_from_in = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    // Main entry drains and refills on the same edge: full throughput.
                    main_from_in = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end else if (in_fire) begin
                    // Downstream stalled: park the new word behind the main entry.
                    skid_load = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                // s_ready is low here, so only the downstream side can move.
                if (m_ready) begin
                    main_from_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // Output decode: everything comes straight from registered state.
    always_comb begin
        m_valid = (state != EMPTY);
        s_ready = (state != FULL);
        count   = state;
    end

    // Data registers. s_data is only sampled on an accepted transfer, so
    // garbage on it while s_valid is low never reaches the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_from_in) begin
                main_q <= s_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (skid_load) begin
                skid_q <= s_data;
            end
        end
    end

    assign m_data = main_q;

endmodule

// File: tb/tb_skid_buffer_pipe.sv
// Testbench for skid_buffer_pipe: directed vector table, reset corner case, random scoreboard.
// Latency: outputs are checked on the falling edge after each rising edge.
// Backpressure: driven by the vectors and by random m_ready in the last phase.
module tb_skid_buffer_pipe;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] count;

    int checks   = 0;
    int failures = 0;

    skid_buffer_pipe #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic [7:0] sd;
        logic       mr;
        logic       exp_mv;
        logic [7:0] exp_md;
        logic       exp_sr;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic mv, input logic [7:0] md,
                                 input logic sr, input logic [1:0] cnt);
        check({tag, "_m_valid"}, 32'(m_valid), 32'(mv));
        check({tag, "_m_data"},  32'(m_data),  32'(md));
        check({tag, "_s_ready"}, 32'(s_ready), 32'(sr));
        check({tag, "_count"},   32'(count),   32'(cnt));
    endtask

    task automatic add_vec(input logic sv, input logic [7:0] sd, input logic mr,
                           input logic mv, input logic [7:0] md, input logic sr,
                           input logic [1:0] cnt);
        vec_t v;
        v.sv = sv; v.sd = sd; v.mr = mr;
        v.exp_mv = mv; v.exp_md = md; v.exp_sr = sr; v.exp_cnt = cnt;
        vecs.push_back(v);
    endtask

    // Called on a falling edge; returns on a falling edge with reset released.
    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard model: queue of held words, head is what m_data must show.
    logic [7:0] mq[$];
    logic [7:0] m_last;

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;

        // Single word, then idle with junk on s_data that must not be captured.
        add_vec(1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 2'd1);
        add_vec(1'b0, 8'hEE, 1'b1, 1'b0, 8'hA5, 1'b1, 2'd0);
        // Back-to-back stream, one word out per cycle.
        for (int i = 1; i <= 16; i++) begin
            add_vec(1'b1, 8'(i), 1'b1, 1'b1, 8'(i), 1'b1, 2'd1);
        end
        add_vec(1'b0, 8'h5A, 1'b1, 1'b0, 8'h10, 1'b1, 2'd0);
        // Back-pressure: fill both entries, 0x33 offered while full is refused.
        add_vec(1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1);
        add_vec(1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2);
        add_vec(1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2);
        add_vec(1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1);
        add_vec(1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1);
        add_vec(1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 2'd0);

        // Reset state while rst_n is held low (between clock edges).
        #12;
        check_outputs("reset", 1'b0, 8'h00, 1'b1, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            s_valid = vecs[i].sv;
            s_data  = vecs[i].sd;
            m_ready = vecs[i].mr;
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_mv, vecs[i].exp_md,
                          vecs[i].exp_sr, vecs[i].exp_cnt);
        end

        // Asynchronous reset from FULL, asserted between clock edges.
        do_reset();
        s_valid = 1'b1; m_ready = 1'b0; s_data = 8'h11;
        @(negedge clk);
        s_data = 8'h22;
        @(negedge clk);
        s_valid = 1'b0;
        check_outputs("prefill", 1'b1, 8'h11, 1'b0, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 8'h00, 1'b1, 2'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post_rst%0d_m_valid", i), 32'(m_valid), 32'd0);
            check($sformatf("post_rst%0d_m_data", i), 32'(m_data), 32'h00);
        end

        // Random traffic against a queue model.
        do_reset();
        mq.delete();
        m_last = 8'h00;
        for (int c = 0; c < 2000; c++) begin
            logic sv;
            logic mr;
            logic [7:0] sd;
            logic exp_sr;
            logic exp_mv;
            exp_sr = (mq.size() < 2);
            exp_mv = (mq.size() != 0);
            check($sformatf("rnd%0d_m_valid", c), 32'(m_valid), 32'(exp_mv));
            check($sformatf("rnd%0d_s_ready", c), 32'(s_ready), 32'(exp_sr));
            check($sformatf("rnd%0d_count", c),   32'(count),   32'(mq.size()));
            check($sformatf("rnd%0d_m_data", c),  32'(m_data),  32'(exp_mv ? mq[0] : m_last));

            sv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            sd = 8'($urandom_range(0, 255));
            s_valid = sv;
            m_ready = mr;
            s_data  = sd;
            if (exp_mv && mr) begin
                void'(mq.pop_front());
            end
            if (sv && exp_sr) begin
                mq.push_back(sd);
            end
            if (mq.size() != 0) begin
                m_last = mq[0];
            end
            @(negedge clk);
        end

        s_valid = 1'b0;
        m_ready = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
